// File: rtl/barrel_scheduler.sv
// Barrel scheduler: paces barrel launches round-robin across N_BARRELS slots,
// holds Kong's throw pose before each launch, tracks dodged barrels and a
// sticky game-over on a hit. All outputs come straight from registers.
module barrel_scheduler #(
  parameter int N_BARRELS    = 4,
  parameter int SPAWN_PERIOD = 150_000_000,
  parameter int THROW_CYCLES = 20_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_BARRELS-1:0] barrel_done,
  input  logic [N_BARRELS-1:0] barrel_hit,
  output logic [N_BARRELS-1:0] barrel_launch,
  output logic [N_BARRELS-1:0] active,
  output logic                 throw_anim,
  output logic                 game_over,
  output logic [7:0]           dodged_cnt
);

  localparam int IW = (N_BARRELS > 1) ? $clog2(N_BARRELS) : 1;
  localparam int SW = $clog2(SPAWN_PERIOD + 1);
  localparam int TW = $clog2(THROW_CYCLES + 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_PERIOD - 1);
  localparam logic [TW-1:0] THROW_LAST = TW'(THROW_CYCLES - 1);
  localparam logic [IW-1:0] LAST_INIT  = IW'(N_BARRELS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_THROW, ST_HALT} state_t;

  state_t               r_state, w_state_nxt;
  logic [SW-1:0]        r_spawn, w_spawn_nxt;
  logic [TW-1:0]        r_throw, w_throw_nxt;
  logic [IW-1:0]        r_target, w_target_nxt;
  logic [IW-1:0]        r_last, w_last_nxt;
  logic [N_BARRELS-1:0] r_active, w_active_nxt;
  logic [N_BARRELS-1:0] r_launch, w_launch_nxt;
  logic                 r_anim, w_anim_nxt;
  logic                 r_go, w_go_nxt;
  logic [7:0]           r_dod, w_dod_nxt;
  logic [N_BARRELS-1:0] r_done_q, r_hit_q;

  logic [N_BARRELS-1:0] w_hit_rise, w_dodge, w_tgt_oh;
  logic [7:0]           w_dod_sat;
  logic                 w_found;
  logic [IW-1:0]        w_pick;

  assign active        = r_active;
  assign barrel_launch = r_launch;
  assign throw_anim    = r_anim;
  assign game_over     = r_go;
  assign dodged_cnt    = r_dod;

  // Edge detection: only rising edges on in-flight slots matter; a done with
  // the hit level high is never a dodge.
  always_comb begin
    w_hit_rise = barrel_hit & ~r_hit_q & r_active;
    w_dodge    = barrel_done & ~r_done_q & r_active & ~barrel_hit;
  end

  // Saturating add of all simultaneous dodges.
  always_comb begin
    int unsigned s;
    s = 32'(r_dod);
    for (int i = 0; i < N_BARRELS; i++) s = s + 32'(w_dodge[i]);
    w_dod_sat = (s > 255) ? 8'hFF : 8'(s);
  end

  // Round-robin search for the first free slot after the last launched one.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= N_BARRELS; k++) begin
      idx = (int'(r_last) + k) % N_BARRELS;
      if (!w_found && !r_active[idx]) begin
        w_found = 1'b1;
        w_pick  = IW'(idx);
      end
    end
  end

  // One-hot of the latched target slot.
  always_comb begin
    w_tgt_oh           = '0;
    w_tgt_oh[r_target] = 1'b1;
  end

  // Next-state and next-output logic; a hit edge outranks a pending launch.
  always_comb begin
    w_state_nxt  = r_state;
    w_spawn_nxt  = r_spawn;
    w_throw_nxt  = r_throw;
    w_target_nxt = r_target;
    w_last_nxt   = r_last;
    w_active_nxt = r_active;
    w_launch_nxt = '0;
    w_anim_nxt   = r_anim;
    w_go_nxt     = r_go;
    w_dod_nxt    = r_dod;
    if (!enable) begin
      w_state_nxt  = ST_IDLE;
      w_spawn_nxt  = '0;
      w_throw_nxt  = '0;
      w_target_nxt = '0;
      w_last_nxt   = LAST_INIT;
      w_active_nxt = '0;
      w_anim_nxt   = 1'b0;
      w_go_nxt     = 1'b0;
      w_dod_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_WAIT;
        ST_WAIT, ST_THROW: begin
          if (|w_hit_rise) begin
            w_state_nxt = ST_HALT;
            w_go_nxt    = 1'b1;
            w_anim_nxt  = 1'b0;
          end else begin
            w_active_nxt = r_active & ~w_dodge;
            w_dod_nxt    = w_dod_sat;
            if (r_state == ST_WAIT) begin
              if (r_spawn != SPAWN_LAST) begin
                w_spawn_nxt = r_spawn + 1'b1;
              end else if (w_found) begin
                w_state_nxt  = ST_THROW;
                w_target_nxt = w_pick;
                w_throw_nxt  = '0;
                w_anim_nxt   = 1'b1;
              end
            end else if (r_throw == THROW_LAST) begin
              w_state_nxt  = ST_WAIT;
              w_launch_nxt = w_tgt_oh;
              w_active_nxt = (r_active & ~w_dodge) | w_tgt_oh;
              w_last_nxt   = r_target;
              w_spawn_nxt  = '0;
              w_anim_nxt   = 1'b0;
            end else begin
              w_throw_nxt = r_throw + 1'b1;
            end
          end
        end
        default: ; // ST_HALT: everything frozen until enable drops
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spawn  <= '0;
      r_throw  <= '0;
      r_target <= '0;
      r_last   <= LAST_INIT;
      r_active <= '0;
      r_launch <= '0;
      r_anim   <= 1'b0;
      r_go     <= 1'b0;
      r_dod    <= '0;
    end else begin
      r_spawn  <= w_spawn_nxt;
      r_throw  <= w_throw_nxt;
      r_target <= w_target_nxt;
      r_last   <= w_last_nxt;
      r_active <= w_active_nxt;
      r_launch <= w_launch_nxt;
      r_anim   <= w_anim_nxt;
      r_go     <= w_go_nxt;
      r_dod    <= w_dod_nxt;
    end
  end

  // Previous-value registers for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_q <= '0;
      r_hit_q  <= '0;
    end else begin
      r_done_q <= barrel_done;
      r_hit_q  <= barrel_hit;
    end
  end

endmodule

// File: tb/tb_barrel_scheduler.sv
// Directed bench for barrel_scheduler with N_BARRELS=4, SPAWN_PERIOD=10,
// THROW_CYCLES=3. Launch period from IDLE exit is 13 cycles.
module tb_barrel_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] barrel_done, barrel_hit;
  logic [3:0] barrel_launch, active;
  logic       throw_anim, game_over;
  logic [7:0] dodged_cnt;

  int n_chk = 0;
  int n_err = 0;

  barrel_scheduler #(.N_BARRELS(4), .SPAWN_PERIOD(10), .THROW_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .barrel_done(barrel_done), .barrel_hit(barrel_hit),
    .barrel_launch(barrel_launch), .active(active),
    .throw_anim(throw_anim), .game_over(game_over), .dodged_cnt(dodged_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic [3:0] done;
    logic [3:0] hit;
    int         n;      // clock edges to apply with these inputs
    logic       quiet;  // no throw/launch allowed during the run
    logic [3:0] e_act;
    logic [3:0] e_lau;
    logic       e_thr;
    logic       e_go;
    logic [7:0] e_dod;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic en, logic [3:0] d, logic [3:0] h,
                              int n, logic q, logic [3:0] a, logic [3:0] l,
                              logic t, logic g, logic [7:0] dd);
    vec_t v;
    v.name = nm; v.en = en; v.done = d; v.hit = h; v.n = n; v.quiet = q;
    v.e_act = a; v.e_lau = l; v.e_thr = t; v.e_go = g; v.e_dod = dd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, active, barrel_launch, throw_anim, game_over, dodged_cnt};
  endfunction

  function automatic logic [31:0] pack(logic [3:0] a, logic [3:0] l, logic t,
                                       logic g, logic [7:0] d);
    return {14'd0, a, l, t, g, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic bad;
    int   exp_dod;
    int   c;
    logic [3:0] mask;

    //          name           en done     hit      n   q   act      lau      thr go  dod
    tbl.push_back(mk("boot_wait",   1, 4'b0000, 4'b0000, 10, 1, 4'b0000, 4'b0000, 0, 0, 8'd0));
    tbl.push_back(mk("throw_start", 1, 4'b0000, 4'b0000,  1, 0, 4'b0000, 4'b0000, 1, 0, 8'd0));
    tbl.push_back(mk("throw_hold",  1, 4'b0000, 4'b0000,  2, 0, 4'b0000, 4'b0000, 1, 0, 8'd0));
    tbl.push_back(mk("launch0",     1, 4'b0000, 4'b0000,  1, 0, 4'b0001, 4'b0001, 0, 0, 8'd0));
    tbl.push_back(mk("launch_1cyc", 1, 4'b0000, 4'b0000,  1, 0, 4'b0001, 4'b0000, 0, 0, 8'd0));
    tbl.push_back(mk("launch1",     1, 4'b0000, 4'b0000, 12, 0, 4'b0011, 4'b0010, 0, 0, 8'd0));
    tbl.push_back(mk("launch2",     1, 4'b0000, 4'b0000, 13, 0, 4'b0111, 4'b0100, 0, 0, 8'd0));
    tbl.push_back(mk("launch3",     1, 4'b0000, 4'b0000, 13, 0, 4'b1111, 4'b1000, 0, 0, 8'd0));
    tbl.push_back(mk("full_quiet",  1, 4'b0000, 4'b0000, 30, 1, 4'b1111, 4'b0000, 0, 0, 8'd0));
    tbl.push_back(mk("done_slot2",  1, 4'b0100, 4'b0000,  1, 0, 4'b1011, 4'b0000, 0, 0, 8'd1));
    tbl.push_back(mk("done_level",  1, 4'b0100, 4'b0000,  1, 0, 4'b1011, 4'b0000, 1, 0, 8'd1));
    tbl.push_back(mk("relaunch2",   1, 4'b0000, 4'b0000,  3, 0, 4'b1111, 4'b0100, 0, 0, 8'd1));
    tbl.push_back(mk("hit_slot1",   1, 4'b0010, 4'b0010,  1, 0, 4'b1111, 4'b0000, 0, 1, 8'd1));
    tbl.push_back(mk("halt_quiet",  1, 4'b0010, 4'b0010, 20, 1, 4'b1111, 4'b0000, 0, 1, 8'd1));
    tbl.push_back(mk("halt_done",   1, 4'b0011, 4'b0000,  1, 0, 4'b1111, 4'b0000, 0, 1, 8'd1));
    tbl.push_back(mk("disable",     0, 4'b0000, 4'b0000,  1, 0, 4'b0000, 4'b0000, 0, 0, 8'd0));
    tbl.push_back(mk("idle_quiet",  0, 4'b0000, 4'b0000,  5, 1, 4'b0000, 4'b0000, 0, 0, 8'd0));
    tbl.push_back(mk("reen_throw",  1, 4'b0000, 4'b0000, 12, 0, 4'b0000, 4'b0000, 1, 0, 8'd0));
    tbl.push_back(mk("abort",       0, 4'b0000, 4'b0000,  1, 0, 4'b0000, 4'b0000, 0, 0, 8'd0));
    tbl.push_back(mk("abort_quiet", 0, 4'b0000, 4'b0000,  6, 1, 4'b0000, 4'b0000, 0, 0, 8'd0));

    rst = 1'b1; enable = 1'b0; barrel_done = '0; barrel_hit = '0;
    repeat (3) cyc();
    chk("reset", outs(), pack(4'b0000, 4'b0000, 0, 0, 8'd0));
    rst = 1'b0;

    // Table-driven sequence: boot, fill all slots, free/relaunch, hit, disable, abort.
    foreach (tbl[i]) begin
      enable = tbl[i].en; barrel_done = tbl[i].done; barrel_hit = tbl[i].hit;
      bad = 1'b0;
      for (int k = 0; k < tbl[i].n; k++) begin
        cyc();
        if (tbl[i].quiet && (throw_anim || barrel_launch != 4'b0000)) bad = 1'b1;
      end
      if (tbl[i].quiet) chk({tbl[i].name, "_activity"}, 32'(bad), 32'd0);
      chk(tbl[i].name, outs(),
          pack(tbl[i].e_act, tbl[i].e_lau, tbl[i].e_thr, tbl[i].e_go, tbl[i].e_dod));
    end

    // Saturation: refill all slots, then retire them in bulk until dodged_cnt pins at 255.
    enable = 1'b1; barrel_done = '0; barrel_hit = '0;
    exp_dod = 0;
    for (int r = 0; r < 66; r++) begin
      c = 0;
      while (active != 4'b1111 && c < 400) begin
        cyc();
        c++;
      end
      chk("refill", {28'd0, active}, 32'h0000000F);
      mask = (r < 63) ? 4'b1111 : 4'b0011;
      barrel_done = mask;
      cyc();
      barrel_done = '0;
      exp_dod = exp_dod + $countones(mask);
      if (exp_dod > 255) exp_dod = 255;
      chk("dodged_sat", {24'd0, dodged_cnt}, 32'(exp_dod));
      chk("active_freed", {28'd0, active}, {28'd0, ~mask});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
